// File: rtl/sram_word_bridge_if.sv
// ----------------------------------------------------------------------------
// sram_word_bridge_if
//
// Purpose:
//   PicoRV32 native memory bus as seen by one memory-mapped slave, after the
//   SoC address decoder has already selected the block.
//
// Signals:
//   mem_valid  request, held by the master until mem_ready
//   mem_ready  one-cycle completion pulse from the slave
//   mem_addr   32-bit byte address (bits [1:0] unused by word slaves)
//   mem_wdata  write data, byte lane k = bits [8k+7:8k]
//   mem_wstrb  byte enables, 4'b0000 means read
//   mem_rdata  read data, valid while mem_ready is high
//
// Modports:
//   master  CPU / decoder side
//   slave   memory block side
// ----------------------------------------------------------------------------
interface sram_word_bridge_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/sram_word_bridge.sv
// ----------------------------------------------------------------------------
// sram_word_bridge
//
// Purpose:
//   Bridges the 32-bit PicoRV32 native memory bus onto an 8K x 8 single-port
//   BSRAM macro. Every word access is broken into byte-lane SRAM cycles:
//   writes touch only the strobed lanes in ascending order, reads fetch all
//   four lanes with overlapped issue/capture and assemble the word.
//
// Parameters:
//   ADDR_WIDTH  SRAM byte-address width (word index = mem_addr[ADDR_WIDTH-1:2])
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   mem         sram_word_bridge_if.slave (mem_valid/ready/addr/wdata/wstrb/rdata)
//   sram_ce     SRAM clock enable
//   sram_oce    SRAM output clock enable, tied 1
//   sram_reset  SRAM output reset, tied 0
//   sram_wre    SRAM write enable
//   sram_ad     SRAM byte address
//   sram_din    SRAM write data
//   sram_dout   SRAM read data, valid the cycle after a read issue
//
// Build option:
//   SRAM_WORD_BRIDGE_FAST_READ_EN  when defined, the lane-3 capture cycle is
//   itself the ready cycle: mem_rdata[31:24] comes straight from sram_dout in
//   that cycle and reads finish one cycle earlier (no DONE state for reads).
// ----------------------------------------------------------------------------
module sram_word_bridge #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  resetn,
    sram_word_bridge_if.slave     mem,
    output logic                  sram_ce,
    output logic                  sram_oce,
    output logic                  sram_reset,
    output logic                  sram_wre,
    output logic [ADDR_WIDTH-1:0] sram_ad,
    output logic [7:0]            sram_din,
    input  logic [7:0]            sram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-3:0] word_q, word_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            pend_q, pend_d;
    logic [2:0]            lane_q, lane_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  ce_q, ce_d;
    logic                  wre_q, wre_d;
    logic [ADDR_WIDTH-1:0] ad_q, ad_d;
    logic [7:0]            din_q, din_d;

    logic [1:0]            wr_lane;
    logic [1:0]            iss_lane;
    logic [1:0]            cap_lane;

    // Address bits outside the SRAM window and the byte offset are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_addr[31:ADDR_WIDTH], mem.mem_addr[1:0]};

    // Lowest strobed lane still waiting to be written.
    always_comb begin
        wr_lane = 2'd3;
        if (pend_q[0])      wr_lane = 2'd0;
        else if (pend_q[1]) wr_lane = 2'd1;
        else if (pend_q[2]) wr_lane = 2'd2;
    end

    // Lane 0 is issued straight from IDLE, so lane_q counts READ cycles and
    // the next lane to issue is lane_q+1. The byte on sram_dout belongs to
    // the lane issued two register updates earlier, hence lane_q-1 (lane_q=4
    // wraps to lane 3).
    assign iss_lane = lane_q[1:0] + 2'd1;
    assign cap_lane = lane_q[1:0] - 2'd1;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        ce_d    = 1'b0;
        wre_d   = 1'b0;
        ad_d    = ad_q;
        din_d   = din_q;

        case (state_q)
            IDLE: begin
                lane_d = 3'd0;
                if (mem.mem_valid) begin
                    word_d  = mem.mem_addr[ADDR_WIDTH-1:2];
                    wdata_d = mem.mem_wdata;
                    pend_d  = mem.mem_wstrb;
                    if (mem.mem_wstrb != 4'b0000) begin
                        state_d = WRITE;
                    end else begin
                        // Issuing lane 0 here is what makes the 4-lane read
                        // fit in six cycles.
                        state_d = READ;
                        ce_d    = 1'b1;
                        ad_d    = {mem.mem_addr[ADDR_WIDTH-1:2], 2'd0};
                    end
                end
            end

            WRITE: begin
                if (pend_q != 4'b0000) begin
                    ce_d   = 1'b1;
                    wre_d  = 1'b1;
                    ad_d   = {word_q, wr_lane};
                    din_d  = wdata_q[{wr_lane, 3'b000} +: 8];
                    pend_d = pend_q & ~(4'b0001 << wr_lane);
                end else begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end
            end

            READ: begin
                lane_d = lane_q + 3'd1;
                if (lane_q < 3'd3) begin
                    ce_d = 1'b1;
                    ad_d = {word_q, iss_lane};
                end
                if (lane_q != 3'd0) begin
                    rdata_d[{cap_lane, 3'b000} +: 8] = sram_dout;
                end
`ifdef SRAM_WORD_BRIDGE_FAST_READ_EN
                if (lane_q == 3'd3) begin
                    ready_d = 1'b1;
                end
                if (lane_q == 3'd4) begin
                    state_d = IDLE;
                end
`else
                if (lane_q == 3'd4) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            word_q  <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
            lane_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            ce_q    <= 1'b0;
            wre_q   <= 1'b0;
            ad_q    <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            ce_q    <= ce_d;
            wre_q   <= wre_d;
            ad_q    <= ad_d;
            din_q   <= din_d;
        end
    end

    assign mem.mem_ready = ready_q;
`ifdef SRAM_WORD_BRIDGE_FAST_READ_EN
    // Top byte is taken from the SRAM in the ready cycle itself.
    assign mem.mem_rdata = {((state_q == READ) && (lane_q == 3'd4)) ? sram_dout : rdata_q[31:24],
                            rdata_q[23:0]};
`else
    assign mem.mem_rdata = rdata_q;
`endif

    assign sram_ce    = ce_q;
    assign sram_wre   = wre_q;
    assign sram_ad    = ad_q;
    assign sram_din   = din_q;
    assign sram_oce   = 1'b1;
    assign sram_reset = 1'b0;

endmodule

// File: tb/tb_sram_word_bridge.sv
// ----------------------------------------------------------------------------
// tb_sram_word_bridge
//
// Testbench for sram_word_bridge: behavioural 8K x 8 SRAM, a byte-array
// reference memory, a table of directed transactions, randomized
// transactions and hand-written back-to-back / reset-mid-read sequences.
// ----------------------------------------------------------------------------
module tb_sram_word_bridge;

`ifdef SRAM_WORD_BRIDGE_FAST_READ_EN
    localparam int RD_LAT = 5;
`else
    localparam int RD_LAT = 6;
`endif
    localparam int MAX_WAIT = 20;

    typedef struct {
        logic        wre;
        logic [12:0] ad;
        logic [7:0]  din;
    } sram_op_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        sram_ce;
    logic        sram_oce;
    logic        sram_reset;
    logic        sram_wre;
    logic [12:0] sram_ad;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;

    logic [7:0]  sram_mem [0:8191];
    logic [7:0]  ref_mem  [0:8191];
    sram_op_t    sram_log [$];
    logic [31:0] last_rdata;

    int n_checks;
    int n_fail;

    sram_word_bridge_if bus ();

    sram_word_bridge #(
        .ADDR_WIDTH (13)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem        (bus),
        .sram_ce    (sram_ce),
        .sram_oce   (sram_oce),
        .sram_reset (sram_reset),
        .sram_wre   (sram_wre),
        .sram_ad    (sram_ad),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro in bypass mode plus a log of every enabled cycle.
    always @(posedge clk) begin
        if (sram_ce) begin
            sram_op_t op;
            op.wre = sram_wre;
            op.ad  = sram_ad;
            op.din = sram_din;
            sram_log.push_back(op);
            if (sram_wre) sram_mem[sram_ad] <= sram_din;
            else          sram_dout <= sram_mem[sram_ad];
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drives one request, scrambles the bus inputs once accepted, waits for
    // mem_ready and returns data and latency (cycles after acceptance).
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb,
                                 output logic [31:0] rdata, output int lat);
        bit got;
        got   = 1'b0;
        lat   = 0;
        rdata = '0;
        sram_log.delete();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        for (int i = 0; i < MAX_WAIT && !got; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.mem_addr  = $urandom;
                bus.mem_wdata = $urandom;
                bus.mem_wstrb = 4'($urandom);
            end
            lat++;
            if (bus.mem_ready) begin
                got   = 1'b1;
                rdata = bus.mem_rdata;
            end
        end
        bus.mem_valid = 1'b0;
        checkOutput("handshake_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        checkOutput("ready_one_cycle", 32'(bus.mem_ready), 32'd0);
    endtask

    task automatic checkTransaction(input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [3:0] wstrb, input bit use_table,
                                    input logic [31:0] tbl_rdata, input int tbl_lat);
        logic [31:0] got_rdata;
        logic [31:0] exp_rdata;
        int          got_lat;
        int          exp_lat;
        int          word;
        sram_op_t    exp_ops [$];
        sram_op_t    op;

        word = int'(addr[12:2]);
        if (wstrb == 4'b0000) begin
            exp_lat   = RD_LAT;
            exp_rdata = {ref_mem[word*4+3], ref_mem[word*4+2], ref_mem[word*4+1], ref_mem[word*4]};
            for (int k = 0; k < 4; k++) begin
                op.wre = 1'b0;
                op.ad  = 13'(word*4 + k);
                op.din = 8'h00;
                exp_ops.push_back(op);
            end
        end else begin
            exp_lat   = $countones(wstrb) + 2;
            exp_rdata = last_rdata;
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) begin
                    op.wre = 1'b1;
                    op.ad  = 13'(word*4 + k);
                    op.din = wdata[8*k +: 8];
                    exp_ops.push_back(op);
                end
            end
        end

        applyStimulus(addr, wdata, wstrb, got_rdata, got_lat);

        checkOutput("latency", 32'(got_lat), 32'(exp_lat));
        checkOutput("rdata", got_rdata, exp_rdata);
        if (use_table) begin
            checkOutput("table_latency", 32'(got_lat), 32'(tbl_lat));
            if (wstrb == 4'b0000) checkOutput("table_rdata", got_rdata, tbl_rdata);
        end
        checkOutput("sram_cycles", 32'(sram_log.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < sram_log.size(); i++) begin
            checkOutput("sram_ad", 32'(sram_log[i].ad), 32'(exp_ops[i].ad));
            checkOutput("sram_wre", 32'(sram_log[i].wre), 32'(exp_ops[i].wre));
            if (exp_ops[i].wre) checkOutput("sram_din", 32'(sram_log[i].din), 32'(exp_ops[i].din));
        end

        if (wstrb == 4'b0000) begin
            last_rdata = exp_rdata;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) ref_mem[word*4+k] = wdata[8*k +: 8];
            end
        end
    endtask

    initial begin
        vec_t        vecs [11];
        logic [31:0] r;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [31:0] data1;
        logic [31:0] data2;
        int          pulses;
        int          cyc1;
        int          cyc2;
        bit          switch_now;

        n_checks   = 0;
        n_fail     = 0;
        last_rdata = '0;
        resetn     = 1'b0;
        sram_dout  = 8'h00;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        for (int i = 0; i < 8192; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end

        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0,          6};
        vecs[1]  = '{32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF,  RD_LAT};
        vecs[2]  = '{32'h0000_0010, 32'h00AB_0000, 4'b0100, 32'h0,          3};
        vecs[3]  = '{32'h0000_0010, 32'h0,         4'b0000, 32'hDEAB_BEEF,  RD_LAT};
        vecs[4]  = '{32'h0000_1FFC, 32'h1122_3344, 4'b1111, 32'h0,          6};
        vecs[5]  = '{32'h0000_1FFC, 32'h0,         4'b0000, 32'h1122_3344,  RD_LAT};
        vecs[6]  = '{32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0000,  RD_LAT};
        vecs[7]  = '{32'hFFFF_E014, 32'hCAFE_F00D, 4'b1001, 32'h0,          4};
        vecs[8]  = '{32'h0000_0014, 32'h0,         4'b0000, 32'hCA00_000D,  RD_LAT};
        vecs[9]  = '{32'h0000_0020, 32'h0BAD_C0DE, 4'b1111, 32'h0,          6};
        vecs[10] = '{32'h0000_0022, 32'h0,         4'b0000, 32'h0BAD_C0DE,  RD_LAT};

        // Reset values with the clock running.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        checkOutput("rst_mem_rdata", bus.mem_rdata, 32'd0);
        checkOutput("rst_sram_ce", 32'(sram_ce), 32'd0);
        checkOutput("rst_sram_wre", 32'(sram_wre), 32'd0);
        checkOutput("rst_sram_ad", 32'(sram_ad), 32'd0);
        checkOutput("rst_sram_din", 32'(sram_din), 32'd0);
        checkOutput("rst_sram_oce", 32'(sram_oce), 32'd1);
        checkOutput("rst_sram_reset", 32'(sram_reset), 32'd0);

        @(negedge clk);
        resetn = 1'b1;
        sram_log.delete();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle_sram_cycles", 32'(sram_log.size()), 32'd0);
        checkOutput("idle_sram_ce", 32'(sram_ce), 32'd0);

        $display("[TB] directed table");
        for (int i = 0; i < 11; i++) begin
            checkTransaction(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b1,
                             vecs[i].exp_rdata, vecs[i].exp_lat);
        end

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            if (r[4]) addr = {r[31:13], 11'h7F0 + 11'(r[7:5]), r[1:0]};
            else      addr = {r[31:13], 7'h0, r[9:6], r[1:0]};
            strb = r[2] ? 4'b0000 : 4'($urandom_range(1, 15));
            checkTransaction(addr, $urandom, strb, 1'b0, 32'h0, 0);
        end

        $display("[TB] back-to-back reads");
        exp1 = {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]};
        exp2 = {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
        data1 = '0;
        data2 = '0;
        pulses = 0;
        cyc1 = 0;
        cyc2 = 0;
        switch_now = 1'b0;
        sram_log.delete();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h10;
        bus.mem_wstrb = 4'b0000;
        for (int c = 1; c <= 40 && pulses < 2; c++) begin
            @(posedge clk); #1;
            if (switch_now) begin
                bus.mem_addr = 32'h20;
                switch_now = 1'b0;
            end
            if (bus.mem_ready) begin
                pulses++;
                if (pulses == 1) begin
                    data1 = bus.mem_rdata;
                    cyc1 = c;
                    switch_now = 1'b1;
                end else begin
                    data2 = bus.mem_rdata;
                    cyc2 = c;
                end
            end
        end
        bus.mem_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.mem_ready) pulses++;
        end
        checkOutput("b2b_pulses", 32'(pulses), 32'd2);
        checkOutput("b2b_first_lat", 32'(cyc1), 32'(RD_LAT));
        checkOutput("b2b_gap", 32'(cyc2 - cyc1), 32'(RD_LAT + 1));
        checkOutput("b2b_data1", data1, exp1);
        checkOutput("b2b_data2", data2, exp2);
        checkOutput("b2b_sram_cycles", 32'(sram_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < sram_log.size(); i++) begin
            checkOutput("b2b_sram_ad", 32'(sram_log[i].ad),
                        (i < 4) ? 32'(16 + i) : 32'(32 + i - 4));
        end
        last_rdata = exp2;

        $display("[TB] reset during read");
        bus.mem_addr  = 32'h10;
        bus.mem_wstrb = 4'b0000;
        bus.mem_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("lane2_issue_ce", 32'(sram_ce), 32'd1);
        checkOutput("lane2_issue_ad", 32'(sram_ad), 32'h012);
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        checkOutput("midrst_sram_ce", 32'(sram_ce), 32'd0);
        checkOutput("midrst_mem_ready", 32'(bus.mem_ready), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.mem_ready) pulses++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.mem_ready) pulses++;
        end
        checkOutput("midrst_no_ready", 32'(pulses), 32'd0);
        checkOutput("midrst_rdata", bus.mem_rdata, 32'd0);
        last_rdata = '0;
        checkTransaction(32'h10, 32'h0, 4'b0000, 1'b0, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
